// File: rtl/tile_draw_scheduler.sv
// Walks every cell of the sliding-puzzle board, fetches its tile value and launches one or two
// digit draws on the shared drawer. Optional build macro: TILE_SKIP_BLANK_EN (blank cells not drawn).
module tile_draw_scheduler #(
    parameter int         GRID    = 4,
    parameter int         TILE_W  = 30,
    parameter int         TILE_H  = 30,
    parameter int         X0      = 20,
    parameter int         Y0      = 0,
    parameter int         XPAD    = 7,
    parameter int         YPAD    = 4,
    parameter int         DIGIT_W = 8,
    parameter logic [2:0] FG      = 3'b111,
    parameter logic [2:0] HL      = 3'b100,
    parameter logic [2:0] BG      = 3'b000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] sel_tile,
    output logic [3:0] board_addr,
    input  logic [3:0] board_data,
    output logic       drw_start,
    input  logic       drw_done,
    output logic [7:0] drw_x,
    output logic [6:0] drw_y,
    output logic [3:0] drw_digit,
    output logic [2:0] drw_colour,
    output logic       busy,
    output logic       done
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] FETCH  = 3'd1;
    localparam logic [2:0] LATCH  = 3'd2;
    localparam logic [2:0] LAUNCH = 3'd3;
    localparam logic [2:0] WAIT   = 3'd4;
    localparam logic [2:0] NEXT   = 3'd5;
    localparam logic [2:0] FIN    = 3'd6;

    localparam logic [3:0] LAST_IDX = 4'(GRID * GRID - 1);

    logic [2:0] stateReg;
    logic [3:0] idxReg;
    logic [3:0] unitsReg;
    logic       unitsPendingReg;
    logic [7:0] cellX;
    logic [6:0] cellY;
    logic [2:0] cellColour;

    // Origin of the first digit inside the current cell; results are truncated to port widths.
    assign cellX      = 8'(X0 + (int'(idxReg) % GRID) * TILE_W + XPAD);
    assign cellY      = 7'(Y0 + (int'(idxReg) / GRID) * TILE_H + YPAD);
    assign cellColour = (idxReg == sel_tile) ? HL : FG;

    always_ff @(posedge clk) begin
        if (reset) begin
            stateReg        <= IDLE;
            idxReg          <= '0;
            unitsReg        <= '0;
            unitsPendingReg <= 1'b0;
            board_addr      <= '0;
            drw_start       <= 1'b0;
            drw_x           <= '0;
            drw_y           <= '0;
            drw_digit       <= '0;
            drw_colour      <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
        end else begin
            drw_start <= 1'b0;
            done      <= 1'b0;
            case (stateReg)
                IDLE: begin
                    if (start) begin
                        stateReg   <= FETCH;
                        idxReg     <= '0;
                        board_addr <= '0;
                        busy       <= 1'b1;
                    end
                end
                FETCH: stateReg <= LATCH;
                LATCH: begin
                    if (board_data == 4'd0) begin
`ifdef TILE_SKIP_BLANK_EN
                        stateReg <= NEXT;
`else
                        // Blank cell: draw a background-coloured 0 to erase whatever was there.
                        drw_x           <= cellX;
                        drw_y           <= cellY;
                        drw_digit       <= 4'd0;
                        drw_colour      <= BG;
                        unitsPendingReg <= 1'b0;
                        drw_start       <= 1'b1;
                        stateReg        <= LAUNCH;
`endif
                    end else if (board_data >= 4'd10) begin
                        drw_x           <= cellX;
                        drw_y           <= cellY;
                        drw_digit       <= 4'd1;
                        drw_colour      <= cellColour;
                        unitsReg        <= board_data - 4'd10;
                        unitsPendingReg <= 1'b1;
                        drw_start       <= 1'b1;
                        stateReg        <= LAUNCH;
                    end else begin
                        drw_x           <= cellX;
                        drw_y           <= cellY;
                        drw_digit       <= board_data;
                        drw_colour      <= cellColour;
                        unitsPendingReg <= 1'b0;
                        drw_start       <= 1'b1;
                        stateReg        <= LAUNCH;
                    end
                end
                LAUNCH: stateReg <= WAIT;
                WAIT: begin
                    if (drw_done) begin
                        if (unitsPendingReg) begin
                            drw_x           <= drw_x + 8'(DIGIT_W);
                            drw_digit       <= unitsReg;
                            unitsPendingReg <= 1'b0;
                            drw_start       <= 1'b1;
                            stateReg        <= LAUNCH;
                        end else begin
                            stateReg <= NEXT;
                        end
                    end
                end
                NEXT: begin
                    if (idxReg == LAST_IDX) begin
                        stateReg <= FIN;
                        done     <= 1'b1;
                    end else begin
                        idxReg     <= idxReg + 4'd1;
                        board_addr <= idxReg + 4'd1;
                        stateReg   <= FETCH;
                    end
                end
                FIN: begin
                    busy     <= 1'b0;
                    stateReg <= IDLE;
                end
                default: stateReg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tile_draw_scheduler.sv
// Scoreboard bench for tile_draw_scheduler: synchronous board RAM model, digit drawer model,
// expected launches queued at each start and compared on every drw_start.
module tb_tile_draw_scheduler;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [3:0] sel_tile = 4'd0;
    logic [3:0] board_addr;
    logic [3:0] board_data;
    logic       drw_start;
    logic       drw_done;
    logic [7:0] drw_x;
    logic [6:0] drw_y;
    logic [3:0] drw_digit;
    logic [2:0] drw_colour;
    logic       busy;
    logic       done;

    logic drawerDone = 1'b0;
    logic spuriousDone = 1'b0;
    assign drw_done = drawerDone | spuriousDone;

`ifdef TILE_SKIP_BLANK_EN
    localparam int EXP_RUN1 = 21;
`else
    localparam int EXP_RUN1 = 22;
`endif

    tile_draw_scheduler dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .sel_tile  (sel_tile),
        .board_addr(board_addr),
        .board_data(board_data),
        .drw_start (drw_start),
        .drw_done  (drw_done),
        .drw_x     (drw_x),
        .drw_y     (drw_y),
        .drw_digit (drw_digit),
        .drw_colour(drw_colour),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    logic [3:0] mem [16];
    always @(posedge clk) board_data <= mem[board_addr];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drawer model: done pulse doneDelay cycles after each launch, aborted by reset.
    int doneDelay = 5;
    int cnt = -1;
    always @(negedge clk) begin
        drawerDone = 1'b0;
        if (reset) cnt = -1;
        else if (drw_start) cnt = doneDelay;
        else if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
                drawerDone = 1'b1;
                cnt = -1;
            end
        end
    end

    logic [21:0] expQ[$];
    logic [21:0] launchLog[$];
    logic [21:0] cur;
    logic [21:0] lastLaunch = '0;
    logic        lastValid = 1'b0;
    logic        prevDone = 1'b0;
    int launchCount = 0;
    int doneCount = 0;
    int firstLaunchCyc = -1;
    int lastDoneCyc = -1;

    always @(negedge clk) begin
        cur = {drw_x, drw_y, drw_digit, drw_colour};
        if (reset) begin
            expQ.delete();
            lastValid = 1'b0;
            prevDone = 1'b0;
        end else begin
            if (drw_start) begin
                launchCount++;
                if (firstLaunchCyc < 0) firstLaunchCyc = cyc;
                launchLog.push_back(cur);
                if (expQ.size() == 0) check("launch_expected", 32'(expQ.size() > 0), 1);
                else check("launch", 32'(cur), 32'(expQ.pop_front()));
                lastLaunch = cur;
                lastValid = 1'b1;
            end else if (lastValid) begin
                check("drw_hold", 32'(cur), 32'(lastLaunch));
            end
            if (done) begin
                doneCount++;
                lastDoneCyc = cyc;
                check("busy_with_done", 32'(busy), 1);
            end
            if (prevDone) check("busy_after_done", 32'(busy), 0);
            prevDone = done;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Queue every expected launch for the current board; returns done offset and launch count.
    task automatic pushBoard(output int off, output int nl);
        int x, y, v, nd;
        logic [2:0] col;
        off = 1;
        nl = 0;
        for (int i = 0; i < 16; i++) begin
            v = int'(mem[i]);
            x = 20 + (i % 4) * 30 + 7;
            y = (i / 4) * 30 + 4;
            col = (4'(i) == sel_tile) ? 3'b100 : 3'b111;
            if (v == 0) begin
`ifdef TILE_SKIP_BLANK_EN
                nd = 0;
`else
                expQ.push_back({8'(x), 7'(y), 4'd0, 3'b000});
                nd = 1;
`endif
            end else if (v >= 10) begin
                expQ.push_back({8'(x), 7'(y), 4'd1, col});
                expQ.push_back({8'(x + 8), 7'(y), 4'(v - 10), col});
                nd = 2;
            end else begin
                expQ.push_back({8'(x), 7'(y), 4'(v), col});
                nd = 1;
            end
            nl += nd;
            off += 3 + nd * (1 + doneDelay);
        end
    endtask

    task automatic startPulse(output int c);
        start = 1'b1;
        c = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic waitDone(input int n0, input int maxc);
        int k = 0;
        while (doneCount == n0 && k < maxc) begin
            tick();
            k++;
        end
        check("done_seen", 32'(doneCount != n0), 1);
    endtask

    task automatic loadStdBoard();
        for (int i = 0; i < 16; i++) mem[i] = (i < 15) ? 4'(i + 1) : 4'd0;
    endtask

    initial begin
        #3_000_000;
        $fatal(1, "FAIL watchdog: simulation did not finish");
    end

    initial begin
        int off, nl, c, n0, l0, base, k;
        loadStdBoard();
        sel_tile = 4'd3;
        reset = 1'b1;
        repeat (3) tick();
        check("reset_outputs", 32'({busy, done, drw_start, board_addr, drw_x, drw_y, drw_digit, drw_colour}), 0);
        reset = 1'b0;
        tick();

        // Run 1: standard board, extra start pulse while waiting on the drawer.
        doneDelay = 5;
        pushBoard(off, nl);
        firstLaunchCyc = -1;
        n0 = doneCount;
        l0 = launchCount;
        startPulse(c);
        repeat (5) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        waitDone(n0, 2000);
        check("run1_first_launch_cycle", 32'(firstLaunchCyc), 32'(c + 3));
        check("run1_done_cycle", 32'(lastDoneCyc), 32'(c + off));
        check("run1_launch_count", 32'(launchCount - l0), EXP_RUN1);
        check("run1_done_count", 32'(doneCount - n0), 1);
        tick();
        tick();
        check("run1_idle_busy", 32'(busy), 0);
        check("run1_queue_empty", 32'(expQ.size()), 0);

        // Run 2: directed cells 0..5, random rest, slow drawer, spurious done while idle.
        mem[0] = 4'd7;
        for (int i = 1; i < 5; i++) mem[i] = 4'(i);
        mem[5] = 4'd10;
        for (int i = 6; i < 16; i++) mem[i] = 4'($urandom_range(0, 15));
        sel_tile = 4'd9;
        doneDelay = 50;
        pushBoard(off, nl);
        firstLaunchCyc = -1;
        n0 = doneCount;
        l0 = launchCount;
        base = launchLog.size();
        startPulse(c);
        waitDone(n0, 5000);
        check("run2_first_launch_cycle", 32'(firstLaunchCyc), 32'(c + 3));
        check("run2_done_cycle", 32'(lastDoneCyc), 32'(c + off));
        check("run2_idx0", 32'(launchLog[base]), 32'({8'd27, 7'd4, 4'd7, 3'b111}));
        check("run2_idx5_tens", 32'(launchLog[base + 5]), 32'({8'd57, 7'd34, 4'd1, 3'b111}));
        check("run2_idx5_units", 32'(launchLog[base + 6]), 32'({8'd65, 7'd34, 4'd0, 3'b111}));
        repeat (5) tick();
        spuriousDone = 1'b1;
        tick();
        spuriousDone = 1'b0;
        repeat (5) tick();
        check("run2_no_extra_launch", 32'(launchCount - l0), 32'(nl));
        check("run2_done_count", 32'(doneCount - n0), 1);

        // Run 3: reset while waiting on the drawer, then a full redraw from cell 0.
        loadStdBoard();
        sel_tile = 4'd3;
        doneDelay = 5;
        pushBoard(off, nl);
        n0 = doneCount;
        l0 = launchCount;
        startPulse(c);
        k = 0;
        while (launchCount < l0 + 3 && k < 200) begin
            tick();
            k++;
        end
        check("run3_reached_wait", 32'(launchCount >= l0 + 3), 1);
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("run3_reset_outputs", 32'({busy, done, drw_start, board_addr, drw_x, drw_y, drw_digit, drw_colour}), 0);
        reset = 1'b0;
        tick();
        check("run3_no_done_on_reset", 32'(doneCount - n0), 0);
        pushBoard(off, nl);
        firstLaunchCyc = -1;
        n0 = doneCount;
        l0 = launchCount;
        base = launchLog.size();
        startPulse(c);
        waitDone(n0, 2000);
        check("run3_first_launch", 32'(launchLog[base]), 32'({8'd27, 7'd4, 4'd1, 3'b111}));
        check("run3_first_launch_cycle", 32'(firstLaunchCyc), 32'(c + 3));
        check("run3_done_cycle", 32'(lastDoneCyc), 32'(c + off));
        check("run3_launch_count", 32'(launchCount - l0), EXP_RUN1);
        tick();
        tick();
        check("run3_idle_busy", 32'(busy), 0);
        check("run3_queue_empty", 32'(expQ.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
